// File: rtl/fir_sample_deserializer.sv
// Reassembles narrow BW_CHUNK-wide chunks into BW_SAMPLE-wide samples and presents them
// to the downstream FIR over valid/ready, with sticky framing and overrun flags.
module fir_sample_deserializer #(
  parameter int BW_CHUNK  = 2,
  parameter int BW_SAMPLE = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BW_CHUNK-1:0]  chunk_in,
  input  logic                 chunk_valid,
  input  logic                 sof,
  output logic [BW_SAMPLE-1:0] sample_out,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clear_err
);

  localparam int N_CHUNKS = BW_SAMPLE / BW_CHUNK;
  localparam int CNT_W    = $clog2(N_CHUNKS + 1);

  generate
    if ((BW_SAMPLE % BW_CHUNK) != 0 || N_CHUNKS < 1) begin : g_param_check
      $error("BW_SAMPLE must be a non-zero multiple of BW_CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [BW_SAMPLE-1:0] shift_reg, shift_next;
  logic [BW_SAMPLE-1:0] base_word, assembled_word;
  logic [CNT_W-1:0]     chunk_idx;
  logic                 accept_first, accept_cont, take_chunk, complete, frame_evt;

  logic [BW_SAMPLE-1:0] sample_out_reg, sample_out_next;
  logic                 sample_valid_reg, sample_valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg, overrun_next;
  logic                 transfer, load, drop;

  // State register (collector FSM, counter, partial word)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
    end
  end

  // FSM decode: a sof chunk always restarts at slot 0, even mid-sample
  always_comb begin
    accept_first = chunk_valid & sof;
    accept_cont  = chunk_valid & ~sof & (state_reg == COLLECT);
    frame_evt    = accept_first & (state_reg == COLLECT);
    take_chunk   = accept_first | accept_cont;
    chunk_idx    = accept_first ? '0 : count_reg;
    complete     = take_chunk && (chunk_idx == CNT_W'(N_CHUNKS - 1));
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    if (complete) begin
      state_next = IDLE;
      count_next = '0;
    end else if (take_chunk) begin
      state_next = COLLECT;
      count_next = chunk_idx + CNT_W'(1);
    end
  end

  assign base_word = accept_first ? '0 : shift_reg;

  // Each chunk slot owns a fixed bit field; the slot order depends on MSB_FIRST
  generate
    for (genvar gi = 0; gi < N_CHUNKS; gi++) begin : g_slot
      localparam int SLOT = MSB_FIRST ? (N_CHUNKS - 1 - gi) : gi;
      assign assembled_word[SLOT*BW_CHUNK +: BW_CHUNK] =
        (take_chunk && chunk_idx == CNT_W'(gi)) ? chunk_in
                                                : base_word[SLOT*BW_CHUNK +: BW_CHUNK];
    end
  endgenerate

  always_comb begin
    shift_next = shift_reg;
    if (complete) begin
      shift_next = '0;
    end else if (take_chunk) begin
      shift_next = assembled_word;
    end
  end

  // Output handshake: a completed sample is only dropped if the slot stays occupied
  always_comb begin
    transfer          = sample_valid_reg & sample_ready;
    load              = complete & (~sample_valid_reg | sample_ready);
    drop              = complete & sample_valid_reg & ~sample_ready;
    sample_out_next   = load ? assembled_word : sample_out_reg;
    sample_valid_next = load ? 1'b1 : (transfer ? 1'b0 : sample_valid_reg);
    frame_err_next    = frame_evt | (frame_err_reg & ~clear_err);
    overrun_next      = drop | (overrun_reg & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_out_reg   <= '0;
      sample_valid_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      sample_out_reg   <= sample_out_next;
      sample_valid_reg <= sample_valid_next;
      frame_err_reg    <= frame_err_next;
      overrun_reg      <= overrun_next;
    end
  end

  assign sample_out   = sample_out_reg;
  assign sample_valid = sample_valid_reg;
  assign frame_err    = frame_err_reg;
  assign overrun      = overrun_reg;

endmodule
